// File: rtl/i2s_rx_frame_writer_if.sv
// Signal bundle between the I2S pins, the input DP RAM write port and i2s_rx_frame_writer.
// The pattern_en input is present only when I2S_RX_PATTERN_EN is defined.
interface i2s_rx_frame_writer_if #(
  parameter int NLINES = 8,
  parameter int FRAMES = 32
);
  localparam int CHAN_W  = $clog2(2 * NLINES);
  localparam int FRAME_W = $clog2(FRAMES);

  logic                      en;
  logic                      sck;
  logic                      ws;
  logic [NLINES-1:0]         sd;
`ifdef I2S_RX_PATTERN_EN
  logic                      pattern_en;
`endif
  logic                      we;
  logic [FRAME_W+CHAN_W-1:0] waddr;
  logic [15:0]               wdata;
  logic [FRAME_W-1:0]        frame;
  logic                      frame_done;
  logic                      overrun;

  // master: the receiver (I2S in, RAM write port out)
  modport master (
    input  en, sck, ws, sd,
`ifdef I2S_RX_PATTERN_EN
    input  pattern_en,
`endif
    output we, waddr, wdata, frame, frame_done, overrun
  );

  // slave: the I2S source / RAM side facing the receiver
  modport slave (
    output en, sck, ws, sd,
`ifdef I2S_RX_PATTERN_EN
    output pattern_en,
`endif
    input  we, waddr, wdata, frame, frame_done, overrun
  );
endinterface

// File: rtl/i2s_rx_frame_writer.sv
// Multi-line I2S receiver that writes every captured sample to the input DP RAM at {frame, chan}.
// Optional feature macro I2S_RX_PATTERN_EN adds pattern_en (wdata = zero-extended {frame, chan}).
module i2s_rx_frame_writer #(
  parameter int NLINES = 8,
  parameter int FRAMES = 32
) (
  input  logic                  ck,
  input  logic                  rst,
  i2s_rx_frame_writer_if.master bus
);
  localparam int CHAN_W  = $clog2(2 * NLINES);
  localparam int FRAME_W = $clog2(FRAMES);
  localparam int IDX_W   = (NLINES > 1) ? $clog2(NLINES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_WRITE} state_t;

  state_t                   state_q, state_d;

  logic [2:0]               sck_sync_q;
  logic [1:0]               ws_sync_q;
  logic [NLINES-1:0]        sd_s1_q, sd_s2_q;

  logic                     ws_prev_q;
  logic [4:0]               bitcnt_q;
  logic [NLINES-1:0][15:0]  shreg_q;
  logic [15:0]              word_q [NLINES];
  logic                     side_q;
  logic [IDX_W-1:0]         idx_q;
  logic [FRAME_W-1:0]       frame_q;
  logic                     done_q;
  logic                     overrun_q;

  logic                     rise;
  logic                     ws_now;
  logic                     boundary;
  logic                     take_bit;
  logic [4:0]               bitcnt_inc;
  logic [4:0]               align_sh;
  logic                     latch;
  logic                     last_write;
  logic [CHAN_W-1:0]        chan;
  logic [FRAME_W-1:0]       frame_inc;
  logic [NLINES-1:0][15:0]  shifted_w;
  logic [NLINES-1:0][15:0]  aligned_w;

  assign rise       = sck_sync_q[1] & ~sck_sync_q[2];
  assign ws_now     = ws_sync_q[1];
  assign boundary   = rise && (ws_now != ws_prev_q);
  assign take_bit   = (bitcnt_q < 5'd16);
  assign bitcnt_inc = take_bit ? (bitcnt_q + 5'd1) : bitcnt_q;
  // At a rise bitcnt_inc is 1..16, so a short word is pushed up to the MSB end.
  assign align_sh   = 5'd16 - bitcnt_inc;
  assign latch      = boundary && (state_q == S_RUN) && bus.en;
  assign last_write = (idx_q == IDX_W'(NLINES - 1));
  assign chan       = CHAN_W'({idx_q, side_q});
  assign frame_inc  = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : (frame_q + FRAME_W'(1));

  for (genvar gi = 0; gi < NLINES; gi++) begin : g_line
    assign shifted_w[gi] = take_bit ? {shreg_q[gi][14:0], sd_s2_q[gi]} : shreg_q[gi];
    assign aligned_w[gi] = shifted_w[gi] << align_sh;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_s1_q    <= '0;
      sd_s2_q    <= '0;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], bus.sck};
      ws_sync_q  <= {ws_sync_q[0], bus.ws};
      sd_s1_q    <= bus.sd;
      sd_s2_q    <= sd_s1_q;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!bus.en)                     state_d = S_IDLE;
        else if (boundary && !ws_now)    state_d = S_RUN;
      end
      S_RUN: begin
        if (!bus.en)       state_d = S_IDLE;
        else if (boundary) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_write) state_d = bus.en ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.we    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    if (state_q == S_WRITE) begin
      bus.we    = 1'b1;
      bus.waddr = {frame_q, chan};
`ifdef I2S_RX_PATTERN_EN
      bus.wdata = bus.pattern_en ? 16'({frame_q, chan}) : word_q[idx_q];
`else
      bus.wdata = word_q[idx_q];
`endif
    end
  end

  assign bus.frame      = frame_q;
  assign bus.frame_done = done_q;
  assign bus.overrun    = overrun_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      ws_prev_q <= 1'b0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      side_q    <= 1'b0;
      idx_q     <= '0;
      frame_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NLINES; i++) word_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (rise) begin
        ws_prev_q <= ws_now;
        // Shift first, then a boundary closes the word and restarts the slot.
        bitcnt_q  <= boundary ? 5'd0 : bitcnt_inc;
        shreg_q   <= boundary ? '0 : shifted_w;
      end
      if (latch) begin
        side_q <= ws_prev_q;
        for (int i = 0; i < NLINES; i++) word_q[i] <= aligned_w[i];
      end
      if (boundary && (state_q == S_WRITE)) overrun_q <= 1'b1;
      if (state_q == S_WRITE) begin
        if (last_write) begin
          idx_q <= '0;
          if (side_q) begin
            frame_q <= frame_inc;
            done_q  <= 1'b1;
          end
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx_frame_writer.sv
// Randomised bench for i2s_rx_frame_writer: an I2S source model plus a write/frame scoreboard.
`timescale 1ns/1ps
module tb_i2s_rx_frame_writer;
  localparam int NLINES  = 8;
  localparam int FRAMES  = 32;
  localparam int CHAN_W  = $clog2(2 * NLINES);
  localparam int FRAME_W = $clog2(FRAMES);

  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  i2s_rx_frame_writer_if #(.NLINES(NLINES), .FRAMES(FRAMES)) bus ();

  i2s_rx_frame_writer #(.NLINES(NLINES), .FRAMES(FRAMES)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [FRAME_W+CHAN_W-1:0] addr;
    logic [15:0]               data;
  } wr_t;

  int   n_checks = 0;
  int   n_errors = 0;
  wr_t  exp_q[$];
  int   exp_done_q[$];
  int   m_frame = 0;
  bit   m_pat = 1'b0;
  bit   sb_on = 1'b1;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  logic [15:0] wbuf [NLINES];
  int   d0, w0, n5;
  bit   t6_found, t6_seen;
  int   t6_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected RAM content of one captured slot: first min(slot,16) bits, MSB first, zero-filled.
  function automatic logic [15:0] captured(input logic [15:0] w, input int slot);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v = {v[14:0], (k < slot) ? w[15-k] : 1'b0};
    return v;
  endfunction

  always @(negedge ck) begin
    if (!rst) begin
      if (bus.we) wr_cnt++;
      if (bus.frame_done) begin
        done_cnt++;
        chk("we_with_done", 32'(bus.we), 0);
      end
      if (sb_on && bus.we) begin
        chk("write_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("waddr", 32'(bus.waddr), 32'(e.addr));
          chk("wdata", 32'(bus.wdata), 32'(e.data));
          $display("write addr=%0h data=%0h", bus.waddr, bus.wdata);
        end
      end
      if (sb_on && bus.frame_done) begin
        chk("done_pending", 32'(exp_done_q.size() != 0), 1);
        if (exp_done_q.size() != 0) chk("done_frame", 32'(bus.frame), 32'(exp_done_q.pop_front()));
      end
    end
  end

  task automatic send_bit(input logic ws_v, input logic [NLINES-1:0] sd_v, input int hp);
    bus.sck = 1'b0;
    bus.ws  = ws_v;
    bus.sd  = sd_v;
    repeat (hp) @(negedge ck);
    bus.sck = 1'b1;
    repeat (hp) @(negedge ck);
  endtask

  // One slot of wbuf on every line; its LSB already carries the next word's ws level.
  task automatic send_word(input logic side, input logic next_side, input int slot,
                           input bit expect_it, input int hp);
    wr_t               e;
    logic [NLINES-1:0] b;
    if (expect_it) begin
      for (int i = 0; i < NLINES; i++) begin
        e.addr = {FRAME_W'(m_frame), CHAN_W'(2 * i + int'(side))};
        e.data = m_pat ? 16'(e.addr) : captured(wbuf[i], slot);
        exp_q.push_back(e);
      end
      if (side) begin
        m_frame = (m_frame + 1) % FRAMES;
        exp_done_q.push_back(m_frame);
      end
    end
    for (int k = 0; k < slot; k++) begin
      for (int i = 0; i < NLINES; i++) b[i] = (k < 16) ? wbuf[i][15-k] : 1'($urandom);
      send_bit((k == slot - 1) ? next_side : side, b, hp);
    end
  endtask

  // mode 0: random words, 1: 1000+i / 2000+i, 2: left A5A5 / right random
  task automatic fill(input int mode, input logic side);
    for (int i = 0; i < NLINES; i++) begin
      case (mode)
        1:       wbuf[i] = side ? (16'h2000 + 16'(i)) : (16'h1000 + 16'(i));
        2:       wbuf[i] = side ? 16'($urandom) : 16'hA5A5;
        default: wbuf[i] = 16'($urandom);
      endcase
    end
  endtask

  // A leading right word gives the receiver its right->left lock point.
  task automatic stream(input int nfr, input int slot, input int hp, input int mode);
    fill(0, 1'b1);
    send_word(1'b1, 1'b0, slot, 1'b0, hp);
    for (int f = 0; f < nfr; f++) begin
      fill(mode, 1'b0);
      send_word(1'b0, 1'b1, slot, 1'b1, hp);
      fill(mode, 1'b1);
      send_word(1'b1, 1'b0, slot, 1'b1, hp);
    end
    for (int k = 0; k < 4; k++) send_bit(1'b0, '0, hp);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.sck = 1'b0;
    bus.ws  = 1'b0;
    bus.sd  = '0;
    repeat (3) @(negedge ck);
    rst = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    m_frame = 0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && c < 3000) begin
      @(negedge ck);
      c++;
    end
    repeat (20) @(negedge ck);
    chk(tag, 32'(exp_q.size() + exp_done_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en  = 1'b0;
    bus.sck = 1'b0;
    bus.ws  = 1'b0;
    bus.sd  = '0;
`ifdef I2S_RX_PATTERN_EN
    bus.pattern_en = 1'b0;
`endif
    repeat (3) @(negedge ck);
    chk("rst_we",         32'(bus.we), 0);
    chk("rst_waddr",      32'(bus.waddr), 0);
    chk("rst_wdata",      32'(bus.wdata), 0);
    chk("rst_frame",      32'(bus.frame), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_overrun",    32'(bus.overrun), 0);

    // 16-bit slots, fixed per-line words
    do_reset();
    bus.en = 1'b1;
    d0 = done_cnt;
    stream(1, 16, 4, 1);
    drain("t1_drain");
    chk("t1_done_count", 32'(done_cnt - d0), 1);
    chk("t1_frame", 32'(bus.frame), 1);

    // 32-bit slots: only the top 16 bits are kept
    do_reset();
    bus.en = 1'b1;
    stream(3, 32, 4, 2);
    drain("t2_drain");
    chk("t2_frame", 32'(bus.frame), 3);

    // 33 frames wrap the frame index
    do_reset();
    bus.en = 1'b1;
    d0 = done_cnt;
    stream(33, 16, 4, 0);
    drain("t3_drain");
    chk("t3_done_count", 32'(done_cnt - d0), 33);
    chk("t3_frame", 32'(bus.frame), 1);

    // enable raised in the middle of a right word
    do_reset();
    for (int k = 0; k < 6; k++) send_bit(1'b1, NLINES'($urandom), 4);
    bus.en = 1'b1;
    stream(2, 16, 4, 0);
    drain("t4_drain");
    chk("t4_frame", 32'(bus.frame), 2);

    // 1-bit slots at ck/4: boundaries arrive during write bursts
    do_reset();
    bus.en = 1'b1;
    sb_on  = 1'b0;
    w0 = wr_cnt;
    for (int k = 0; k < 30; k++) send_bit((k % 2 == 0) ? 1'b1 : 1'b0, NLINES'($urandom), 2);
    repeat (30) @(negedge ck);
    n5 = wr_cnt - w0;
    chk("t5_overrun", 32'(bus.overrun), 1);
    chk("t5_burst_complete", 32'(n5 % NLINES), 0);
    chk("t5_some_writes", 32'(n5 > 0), 1);
    chk("t5_words_dropped", 32'(n5 < 20 * NLINES), 1);
    bus.en = 1'b0;
    repeat (20) @(negedge ck);
    chk("t5_overrun_sticky", 32'(bus.overrun), 1);

    // reset during the 3rd write of a burst in frame >= 1
    bus.en   = 1'b1;
    t6_found = 1'b0;
    t6_seen  = 1'b0;
    t6_c     = 0;
    fork
      stream(3, 16, 4, 0);
      begin
        while (!t6_found && t6_c < 20000) begin
          @(negedge ck);
          t6_c++;
          if (bus.frame_done) t6_seen = 1'b1;
          if (t6_seen && bus.we && bus.waddr[CHAN_W-1:0] == CHAN_W'(4)) t6_found = 1'b1;
        end
        if (t6_found) begin
          rst = 1'b1;
          @(negedge ck);
          chk("t6_we_after_rst", 32'(bus.we), 0);
          chk("t6_frame_after_rst", 32'(bus.frame), 0);
          chk("t6_overrun_after_rst", 32'(bus.overrun), 0);
          rst = 1'b0;
        end
        chk("t6_trigger", 32'(t6_found), 1);
      end
    join

`ifdef I2S_RX_PATTERN_EN
    do_reset();
    sb_on = 1'b1;
    m_pat = 1'b1;
    bus.pattern_en = 1'b1;
    bus.en = 1'b1;
    stream(1, 16, 4, 0);
    drain("t6_pattern_drain");
    m_pat = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
